minc_seq: RTL and testbench
===========================

# minc_seq

Execution sequencer for the minc core. It owns the 256 x 9-bit program memory and loads it from a host word stream. It then gates the core with a per-cycle enable, providing free-run to breakpoint, counted single-step and halt. It sits between the host/debug port and the core: the core fetches `instr` at its `pc` and advances only on cycles with `core_en` high.

## Interface
- `ADDR_W`, 8: program address width; depth = 2^ADDR_W
- `WORD_W`, 9: instruction width; bit WORD_W-1 = ADD flag, low 8 bits = operand
- `CLK`  in  1  single clock, rising edge
- `nRESET`  in  1  reset, asynchronous, active-low
- `cmd_valid`  in  1  command offered
- `cmd_ready`  out  1  command accepted when `cmd_valid & cmd_ready` on a rising edge
- `cmd_op`  in  2  00 LOAD, 01 RUN, 10 STEP, 11 HALT
- `cmd_arg`  in  ADDR_W  LOAD: word count-1; RUN: breakpoint address; STEP: step count-1
- `ld_valid`  in  1  load word offered
- `ld_ready`  out  1  load word accepted when `ld_valid & ld_ready` on a rising edge
- `ld_data`  in  WORD_W  program word
- `pc`  in  ADDR_W  core program counter
- `instr`  out  WORD_W  `mem[pc]`, asynchronous read
- `core_en`  out  1  core executes one instruction on this edge
- `core_clr`  out  1  one-cycle pulse; core clears pc and accumulator
- `busy`  out  1  state != IDLE
- `done`  out  1  one-cycle pulse when RUN/STEP ends
- `cmd_err`  out  1  one-cycle pulse on an ignored command

## Operation
- States: IDLE=0, LOAD=1, CLR=2, RUN=3, STEP=4 (3-bit register).
- `cmd_ready` = state in {IDLE, RUN, STEP}; it is 0 in LOAD and CLR.
- IDLE:
  - LOAD → LOAD; `wcnt` <= `cmd_arg`, `waddr` <= 0.
  - RUN → RUN; `brk` <= `cmd_arg`, `first` <= 1.
  - STEP → STEP; `scnt` <= `cmd_arg`.
  - HALT → stays IDLE, no effect, no `cmd_err`.
- LOAD:
  - `ld_ready`=1. Each accepted word: `mem[waddr]` <= `ld_data`, `waddr`++ (wraps at depth).
  - The accepted word with `wcnt`==0 → CLR; otherwise `wcnt`--.
  - `cmd_arg`=255 loads 256 words.
- CLR: `core_clr`=1 for exactly one cycle, then → IDLE.
- RUN:
  - `core_en`=1 except in the break cycle; `first` <= 0 after the first cycle.
  - Break: `pc`==`brk` and `first`==0 → `core_en`=0, → IDLE, `done`=1. The instruction at `brk` is not executed.
  - A RUN issued with `cmd_arg` == current `pc` executes at least one instruction (resume from breakpoint).
- STEP:
  - `core_en`=1 every cycle. While `scnt`!=0, `scnt`--.
  - When `scnt`==0 (that cycle still executes) → IDLE, `done`=1. Exactly `cmd_arg`+1 instructions execute.
- HALT accepted in RUN/STEP:
  - `core_en`=0 in the acceptance cycle; → IDLE; `done`=1.
  - Same cycle as a breakpoint or as `scnt`==0: one `done` only, `core_en`=0.
- LOAD/RUN/STEP accepted in RUN/STEP: ignored, `cmd_err`=1 for one cycle, state unchanged.
- `ld_valid` outside LOAD is ignored (`ld_ready`=0); the memory is not written.
- `pc` outside a RUN/STEP is don't-care for control; `instr` still follows it.

## Timing
- Reset (async assert): state=IDLE, `core_en`=0, `core_clr`=0, `done`=0, `cmd_err`=0, `ld_ready`=0, `busy`=0, `cmd_ready`=1. Counters and `brk` are cleared; memory contents are retained, not cleared.
- Reset mid-LOAD: words already written stay; the unwritten remainder keeps its old contents; no `core_clr` is issued.
- `core_en`, `ld_ready`, `cmd_ready` and `busy` decode from the registered state. `core_en` additionally goes low combinationally on HALT accept or a break match. `done`, `core_clr` and `cmd_err` are registered pulses, asserted in the cycle after the causing edge.
- Latency:
  - command accept edge → first `core_en`=1 cycle: 1 cycle.
  - last load word edge → `core_clr` high: 1 cycle → IDLE 1 cycle later.
- Write-then-read of the same address: `instr` shows the new word after the write edge.

## Test plan
- LOAD `cmd_arg`=3, words 0x005,0x103,0x1FF,0x002 with `ld_valid` gaps → mem[0..3] written in order, one `core_clr` pulse, `cmd_ready` back to 1.
- After load + clear, STEP `cmd_arg`=2 → `core_en` high exactly 3 cycles, core acc = 0x07 (5+3+0xFF mod 256), pc=3, then one `done` pulse.
- RUN `cmd_arg`=0x10 from pc=0 → halts with pc=0x10 and `core_en`=0 that cycle; a second RUN 0x10 executes mem[0x10] before stopping.
- RUN `cmd_arg`=0xFF, then HALT after 5 cycles → exactly 5 instructions executed, `done` once. A STEP offered during RUN gives `cmd_err`=1 and no state change.
- LOAD `cmd_arg`=255 → 256 words written; `waddr` wraps to 0 with no overrun write.
- Assert `nRESET` during LOAD after 2 of 4 words → outputs take their reset values immediately, no `core_clr`, and mem[0..1] hold the new words.

Source files
------------

// File: rtl/minc_seq.sv
// ----------------------------------------------------------------------------
// minc_seq -- execution sequencer for the minc core.
//
// Owns the program memory (2^ADDR_W words of WORD_W bits), fills it from a
// host word stream, and gates the core with a per-cycle enable so the host
// can free-run to a breakpoint, single-step a counted number of
// instructions, or halt.
//
// Ports
//   CLK, nRESET          clock (rising edge), asynchronous active-low reset
//   cmd_valid/cmd_ready  command handshake; cmd_op 00 LOAD 01 RUN 10 STEP 11 HALT
//   cmd_arg              LOAD: words-1, RUN: breakpoint pc, STEP: steps-1
//   ld_valid/ld_ready    program word handshake, ld_data = word
//   pc                   core program counter (input)
//   instr                mem[pc], asynchronous read
//   core_en              core executes one instruction on the next edge
//   core_clr             one-cycle pulse: core clears pc and accumulator
//   busy                 sequencer not idle
//   done                 one-cycle pulse when RUN/STEP ends
//   cmd_err              one-cycle pulse on a command ignored while executing
// ----------------------------------------------------------------------------
module minc_seq #(
    parameter int ADDR_W = 8,
    parameter int WORD_W = 9
) (
    input  logic              CLK,
    input  logic              nRESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_arg,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [WORD_W-1:0] ld_data,
    input  logic [ADDR_W-1:0] pc,
    output logic [WORD_W-1:0] instr,
    output logic              core_en,
    output logic              core_clr,
    output logic              busy,
    output logic              done,
    output logic              cmd_err
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        CLR  = 3'd2,
        RUN  = 3'd3,
        STEP = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_RUN  = 2'b01,
        OP_STEP = 2'b10,
        OP_HALT = 2'b11
    } op_t;

    state_t            state;
    logic [ADDR_W-1:0] wcnt;    // words still to load after the current one
    logic [ADDR_W-1:0] waddr;   // next load address
    logic [ADDR_W-1:0] brk;     // RUN breakpoint
    logic [ADDR_W-1:0] scnt;    // steps still to take after the current one
    logic              first;   // first RUN cycle: breakpoint is not checked

    logic [WORD_W-1:0] mem [DEPTH];

    op_t  op;
    logic in_exec;
    logic cmd_acc;
    logic halt_acc;
    logic bad_cmd;
    logic brk_hit;
    logic wr_en;

    assign op        = op_t'(cmd_op);
    assign in_exec   = (state == RUN) || (state == STEP);
    assign cmd_ready = (state == IDLE) || in_exec;
    assign ld_ready  = (state == LOAD);
    assign busy      = (state != IDLE);
    assign cmd_acc   = cmd_valid && cmd_ready;
    assign halt_acc  = cmd_acc && in_exec && (op == OP_HALT);
    assign bad_cmd   = cmd_acc && in_exec && (op != OP_HALT);
    // The first cycle of a RUN always executes so a RUN issued at the
    // breakpoint address resumes instead of stopping immediately.
    assign brk_hit   = (state == RUN) && !first && (pc == brk);
    assign wr_en     = ld_valid && (state == LOAD);

    // The instruction at a break or halt point must not execute, so the
    // enable is pulled low combinationally in that same cycle.
    assign core_en   = ((state == RUN) && !brk_hit && !halt_acc) ||
                       ((state == STEP) && !halt_acc);

    assign instr     = mem[pc];

    // NOTE: the program memory has no reset branch on purpose: contents must
    // survive nRESET, and leaving it out lets synthesis map it to RAM.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[waddr] <= ld_data;
        end
    end

    // NOTE: every register below is assigned with <= so all of them update
    // from the same pre-edge values; blocking assignments here would let
    // later statements see half-updated state.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state    <= IDLE;
            wcnt     <= '0;
            waddr    <= '0;
            brk      <= '0;
            scnt     <= '0;
            first    <= 1'b0;
            done     <= 1'b0;
            core_clr <= 1'b0;
            cmd_err  <= 1'b0;
        end else begin
            // Pulses default low and are raised only by the causing edge.
            done     <= 1'b0;
            core_clr <= 1'b0;
            cmd_err  <= bad_cmd;

            unique case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        unique case (op)
                            OP_LOAD: begin
                                state <= LOAD;
                                wcnt  <= cmd_arg;
                                waddr <= '0;
                            end
                            OP_RUN: begin
                                state <= RUN;
                                brk   <= cmd_arg;
                                first <= 1'b1;
                            end
                            OP_STEP: begin
                                state <= STEP;
                                scnt  <= cmd_arg;
                            end
                            OP_HALT: ;
                        endcase
                    end
                end

                LOAD: begin
                    if (ld_valid) begin
                        waddr <= waddr + 1'b1;
                        if (wcnt == '0) begin
                            state    <= CLR;
                            core_clr <= 1'b1;
                        end else begin
                            wcnt <= wcnt - 1'b1;
                        end
                    end
                end

                CLR: state <= IDLE;

                RUN: begin
                    first <= 1'b0;
                    if (halt_acc || brk_hit) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end

                STEP: begin
                    // A HALT landing on the last step still gives one done.
                    if (halt_acc || (scnt == '0)) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end else begin
                        scnt <= scnt - 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_minc_seq.sv
// ----------------------------------------------------------------------------
// tb_minc_seq -- self-checking bench for minc_seq.
//
// Contains a small core model (pc/accumulator, ADD flag adds the operand,
// otherwise the operand is loaded) driven by core_en/core_clr, and a shadow
// copy of the program memory used to predict memory contents and core
// results. Loaded words are pushed to a scoreboard queue and popped when
// the memory is read back through instr.
// ----------------------------------------------------------------------------
module tb_minc_seq;

    logic       CLK = 1'b0;
    logic       nRESET = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [7:0] cmd_arg = 8'h00;
    logic       ld_valid = 1'b0;
    logic       ld_ready;
    logic [8:0] ld_data = 9'h000;
    logic [7:0] pc;
    logic [8:0] instr;
    logic       core_en, core_clr, busy, done, cmd_err;

    localparam logic [1:0] C_LOAD = 2'b00, C_RUN = 2'b01, C_STEP = 2'b10, C_HALT = 2'b11;

    minc_seq #(.ADDR_W(8), .WORD_W(9)) dut (
        .CLK(CLK), .nRESET(nRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
        .pc(pc), .instr(instr),
        .core_en(core_en), .core_clr(core_clr), .busy(busy), .done(done), .cmd_err(cmd_err)
    );

    always #5 CLK = ~CLK;

    // ---------------- core model and event counters ----------------
    logic [7:0] core_pc, acc;
    logic       use_ovr = 1'b0;
    logic [7:0] ovr_pc = 8'h00;
    assign pc = use_ovr ? ovr_pc : core_pc;

    always @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            core_pc <= 8'h00;
            acc     <= 8'h00;
        end else if (core_clr) begin
            core_pc <= 8'h00;
            acc     <= 8'h00;
        end else if (core_en) begin
            acc     <= instr[8] ? acc + instr[7:0] : instr[7:0];
            core_pc <= core_pc + 8'h01;
        end
    end

    int en_cnt = 0, done_cnt = 0, clr_cnt = 0;
    always @(posedge CLK) begin
        if (core_en === 1'b1)  en_cnt   <= en_cnt + 1;
        if (done === 1'b1)     done_cnt <= done_cnt + 1;
        if (core_clr === 1'b1) clr_cnt  <= clr_cnt + 1;
    end

    // ---------------- reference state ----------------
    logic [8:0] shadow [256];
    logic [8:0] wbuf [256];

    typedef struct {
        logic [7:0] addr;
        logic [8:0] word;
    } sb_t;
    sb_t sb_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [7:0] arg);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        tick();
        cmd_valid = 1'b0;
    endtask

    // Feed wbuf[0..n-1]; optional idle cycle before every word.
    task automatic load_words(input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                ld_valid = 1'b0;
                tick();
            end
            ld_valid = 1'b1;
            ld_data  = wbuf[i];
            tick();
            shadow[i] = wbuf[i];
            sb_q.push_back('{addr: 8'(i), word: wbuf[i]});
        end
        ld_valid = 1'b0;
    endtask

    // Read memory back through instr and compare with the scoreboard.
    task automatic drain_sb(input string tag);
        sb_t e;
        use_ovr = 1'b1;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            ovr_pc = e.addr;
            #1;
            check(tag, {e.addr, 15'h0, instr}, {e.addr, 15'h0, e.word});
        end
        use_ovr = 1'b0;
        #1;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k = 0;
        while (done !== 1'b1 && k < budget) begin
            tick();
            k++;
        end
        check(tag, done, 1'b1);
    endtask

    // Predicted {pc, acc} after n instructions from (pc0, acc0).
    function automatic logic [15:0] model_run(input logic [7:0] pc0, input logic [7:0] acc0, input int n);
        logic [7:0] p = pc0;
        logic [7:0] a = acc0;
        logic [8:0] w;
        for (int i = 0; i < n; i++) begin
            w = shadow[p];
            a = w[8] ? a + w[7:0] : w[7:0];
            p = p + 8'h01;
        end
        return {p, a};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int en0, d0, c0;
        logic [15:0] exp_pa;

        // ---- reset state ----
        #12;
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_core_en", core_en, 1'b0);
        check("rst_ld_ready", ld_ready, 1'b0);
        check("rst_pulses", {done, core_clr, cmd_err}, 3'b000);
        nRESET = 1'b1;
        tick();

        // ---- LOAD 4 words with gaps ----
        wbuf[0] = 9'h005; wbuf[1] = 9'h103; wbuf[2] = 9'h1FF; wbuf[3] = 9'h002;
        c0 = clr_cnt;
        send_cmd(C_LOAD, 8'd3);
        check("load_state", {busy, ld_ready, cmd_ready}, 3'b110);
        load_words(4, 1'b1);
        check("load_clr_pulse", {core_clr, cmd_ready}, 2'b10);
        tick();
        check("load_clr_end", {core_clr, busy, cmd_ready}, 3'b001);
        check("load_clr_count", clr_cnt - c0, 1);
        drain_sb("load4_mem");

        // ---- STEP 3 ----
        en0 = en_cnt; d0 = done_cnt;
        send_cmd(C_STEP, 8'd2);
        check("step_first_en", core_en, 1'b1);
        wait_done("step_done", 20);
        exp_pa = model_run(8'h00, 8'h00, 3);
        check("step_en_count", en_cnt - en0, 3);
        check("step_acc", acc, 8'h07);
        check("step_acc_model", {core_pc, acc}, exp_pa);
        tick();
        check("step_done_once", {done, busy, done_cnt - d0}, {1'b0, 1'b0, 32'd1});

        // ---- HALT in IDLE: no effect ----
        send_cmd(C_HALT, 8'h00);
        check("halt_idle", {busy, cmd_err}, 2'b00);
        tick();
        check("halt_idle_err", cmd_err, 1'b0);

        // ---- LOAD 256 words, wrap, then stray ld_valid ----
        for (int i = 0; i < 256; i++)
            wbuf[i] = 9'(((i % 3) == 0 ? 256 : 0) + ((i * 37 + 11) % 256));
        send_cmd(C_LOAD, 8'hFF);
        load_words(256, 1'b0);
        check("load256_clr", core_clr, 1'b1);
        ld_valid = 1'b1;
        ld_data  = 9'h0AA;
        tick();
        check("stray_ld_ready", {ld_ready, busy}, 2'b00);
        tick();
        ld_valid = 1'b0;
        drain_sb("load256_mem");

        // ---- RUN to breakpoint 0x10 from pc 0 ----
        check("run_start_pc", core_pc, 8'h00);
        en0 = en_cnt; d0 = done_cnt;
        send_cmd(C_RUN, 8'h10);
        begin
            int k = 0;
            while (core_pc !== 8'h10 && k < 100) begin
                tick();
                k++;
            end
        end
        check("brk_cycle", {core_pc, busy, core_en}, {8'h10, 1'b1, 1'b0});
        tick();
        exp_pa = model_run(8'h00, 8'h00, 16);
        check("brk_done", {done, busy}, 2'b10);
        check("brk_en_count", en_cnt - en0, 16);
        check("brk_pc_acc", {core_pc, acc}, exp_pa);

        // ---- RUN 0x10 again from pc 0x10: full wrap back to 0x10 ----
        en0 = en_cnt;
        send_cmd(C_RUN, 8'h10);
        check("resume_en", core_en, 1'b1);
        wait_done("resume_done", 400);
        exp_pa = model_run(8'h10, exp_pa[7:0], 256);
        check("resume_en_count", en_cnt - en0, 256);
        check("resume_pc_acc", {core_pc, acc}, exp_pa);
        tick();

        // ---- RUN 0xFF, STEP rejected, HALT after 5 instructions ----
        en0 = en_cnt; d0 = done_cnt;
        send_cmd(C_RUN, 8'hFF);
        cmd_valid = 1'b1; cmd_op = C_STEP; cmd_arg = 8'd3;
        tick();
        cmd_valid = 1'b0;
        check("bad_cmd_err", {cmd_err, busy, core_en}, 3'b111);
        tick();
        check("bad_cmd_err_pulse", {cmd_err, busy}, 2'b01);
        repeat (3) tick();
        cmd_valid = 1'b1; cmd_op = C_HALT;
        #1;
        check("halt_en_low", core_en, 1'b0);
        tick();
        cmd_valid = 1'b0;
        exp_pa = model_run(8'h10, exp_pa[7:0], 5);
        check("halt_done", {done, busy}, 2'b10);
        check("halt_en_count", en_cnt - en0, 5);
        check("halt_pc_acc", {core_pc, acc}, exp_pa);
        tick();
        check("halt_done_once", {done, done_cnt - d0}, {1'b0, 32'd1});

        // ---- STEP 1 with HALT on its last cycle: one done, nothing runs ----
        en0 = en_cnt; d0 = done_cnt;
        send_cmd(C_STEP, 8'd0);
        cmd_valid = 1'b1; cmd_op = C_HALT;
        #1;
        check("step_halt_en", core_en, 1'b0);
        tick();
        cmd_valid = 1'b0;
        tick();
        check("step_halt_once", {busy, en_cnt - en0, done_cnt - d0}, {1'b0, 32'd0, 32'd1});

        // ---- reset during LOAD after 2 of 4 words ----
        wbuf[0] = 9'h1A5; wbuf[1] = 9'h03C;
        c0 = clr_cnt;
        send_cmd(C_LOAD, 8'd3);
        load_words(2, 1'b0);
        nRESET = 1'b0;
        #1;
        check("mid_rst_outs", {busy, ld_ready, cmd_ready, core_en, core_clr, done}, 6'b001000);
        #3;
        nRESET = 1'b1;
        tick();
        tick();
        check("mid_rst_no_clr", clr_cnt - c0, 0);
        check("mid_rst_idle", {busy, cmd_ready}, 2'b01);
        sb_q.push_back('{addr: 8'd2, word: shadow[2]});
        sb_q.push_back('{addr: 8'd3, word: shadow[3]});
        drain_sb("mid_rst_mem");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
